operand_tester_chk: RTL and testbench

//  Parametrised operand generator and self-checker for the arithmetic DUTs (adder / multiplier).

---
 rtl/operand_tester_chk.sv | 209 ++++++++++++++++++++
 tb/tb_operand_tester_chk.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_tester_chk.sv
// Operand generator and in-order result checker for adder/multiplier DUTs.
// Issues N_VECTORS operand pairs (sweep, LFSR or corner) while honouring the
// DUT stall. It queues one expected result per issued pair and compares DUT
// results against the queue in order. Run status is reported when the run ends.
module operand_tester_chk #(
    parameter int          A         = 8,
    parameter int          B         = 8,
    parameter int          R_W       = A + B,
    parameter int          N_VECTORS = 256,
    parameter int          EXP_DEPTH = 4,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          TIMEOUT   = 64
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_start,
    input  logic [1:0]     i_mode,
    input  logic           i_op_sel,
    input  logic           i_stall,
    output logic [A-1:0]   o_op_a,
    output logic [B-1:0]   o_op_b,
    output logic           o_op_valid,
    input  logic [R_W-1:0] i_result,
    input  logic           i_result_valid,
    output logic           o_busy,
    output logic           o_done,
    output logic           o_pass,
    output logic           o_timeout,
    output logic [15:0]    o_err_cnt,
    output logic [15:0]    o_first_err_idx
);

    localparam int          PTR_W    = (EXP_DEPTH > 1) ? $clog2(EXP_DEPTH) : 1;
    localparam int          CNT_W    = $clog2(EXP_DEPTH + 1);
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] N_V      = 16'(N_VECTORS);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [1:0]       mode_q;
    logic             op_sel_q;
    logic [15:0]      issued, checked;
    logic [15:0]      lfsr;
    logic [R_W-1:0]   q_mem [EXP_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] q_cnt;
    logic [15:0]      err_cnt, first_err;
    logic             err_seen, spurious_q, timeout_q;
    logic [31:0]      wd;
    logic [A-1:0]     gen_a;
    logic [B-1:0]     gen_b;

    logic start_ok, q_full, q_empty, issue, checking, pop, spurious, wd_expire;

    function automatic logic [R_W-1:0] exp_val(input logic [A-1:0] a,
                                                input logic [B-1:0] b,
                                                input logic mul);
        logic [32:0] wide;
        if (mul) wide = 33'(a) * 33'(b);
        else     wide = 33'(a) + 33'(b);
        return R_W'(wide);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Fibonacci x^16+x^14+x^13+x^11+1, shifting toward the MSB
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(EXP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign start_ok  = i_start && (state == S_IDLE || state == S_DONE);
    assign q_full    = (q_cnt == CNT_W'(EXP_DEPTH));
    assign q_empty   = (q_cnt == '0);
    assign issue     = (state == S_RUN) && !i_stall && !q_full && (issued != N_V);
    assign checking  = (state == S_RUN || state == S_DRAIN) && i_result_valid;
    assign pop       = checking && !q_empty;
    assign spurious  = checking && q_empty;
    assign wd_expire = (state == S_DRAIN) && !i_result_valid && (wd >= 32'(TIMEOUT - 1));

    // Operand pair for the next issue, selected by the latched mode
    always_comb begin
        gen_a = issued[A-1:0];
        gen_b = ~issued[B-1:0];
        case (mode_q)
            2'b01: begin
                gen_a = lfsr[A-1:0];
                gen_b = lfsr[15 -: B];
            end
            2'b10: begin
                case (issued[1:0])
                    2'd0:    begin gen_a = '0; gen_b = '0; end
                    2'd1:    begin gen_a = '1; gen_b = '1; end
                    2'd2:    begin gen_a = '1; gen_b = '0; end
                    default: begin gen_a = '0; gen_b = '1; end
                endcase
            end
            default: ;
        endcase
    end

    // Next-state logic of the run sequencer
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_ok) state_nxt = S_RUN;
            S_RUN:   if (issued == N_V) state_nxt = S_DRAIN;
            S_DRAIN: if ((q_empty && checked == N_V) || wd_expire) state_nxt = S_DONE;
            S_DONE:  if (start_ok) state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Issue, expected-queue bookkeeping, result checking and watchdog
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            mode_q     <= 2'b00;
            op_sel_q   <= 1'b0;
            issued     <= '0;
            checked    <= '0;
            lfsr       <= SEED_EFF;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            q_cnt      <= '0;
            err_cnt    <= '0;
            first_err  <= 16'hFFFF;
            err_seen   <= 1'b0;
            spurious_q <= 1'b0;
            timeout_q  <= 1'b0;
            wd         <= '0;
            o_op_a     <= '0;
            o_op_b     <= '0;
            o_op_valid <= 1'b0;
        end else if (start_ok) begin
            mode_q     <= i_mode;
            op_sel_q   <= i_op_sel;
            issued     <= '0;
            checked    <= '0;
            lfsr       <= SEED_EFF;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            q_cnt      <= '0;
            err_cnt    <= '0;
            first_err  <= 16'hFFFF;
            err_seen   <= 1'b0;
            spurious_q <= 1'b0;
            timeout_q  <= 1'b0;
            wd         <= '0;
            o_op_valid <= 1'b0;
        end else begin
            o_op_valid <= issue;
            if (issue) begin
                o_op_a <= gen_a;
                o_op_b <= gen_b;
                issued <= issued + 16'd1;
                wr_ptr <= ptr_inc(wr_ptr);
                if (mode_q == 2'b01) lfsr <= lfsr_step(lfsr);
            end
            if (pop) begin
                rd_ptr  <= ptr_inc(rd_ptr);
                checked <= checked + 16'd1;
                if (i_result != q_mem[rd_ptr]) begin
                    err_cnt <= sat_inc(err_cnt);
                    if (!err_seen) begin
                        first_err <= checked;
                        err_seen  <= 1'b1;
                    end
                end
            end
            if (spurious) begin
                err_cnt    <= sat_inc(err_cnt);
                spurious_q <= 1'b1;
            end
            case ({issue, pop})
                2'b10:   q_cnt <= q_cnt + CNT_W'(1);
                2'b01:   q_cnt <= q_cnt - CNT_W'(1);
                default: ;
            endcase
            if (state == S_DRAIN && !i_result_valid) wd <= wd + 32'd1;
            else                                     wd <= '0;
            if (wd_expire) timeout_q <= 1'b1;
        end
    end

    // Expected-value storage, written on the same edge the operands register
    always_ff @(posedge i_clk) begin
        if (issue) q_mem[wr_ptr] <= exp_val(gen_a, gen_b, op_sel_q);
    end

    assign o_busy          = (state == S_RUN) || (state == S_DRAIN);
    assign o_done          = (state == S_DONE);
    assign o_pass          = o_done && (err_cnt == 16'd0) && !spurious_q && !timeout_q;
    assign o_timeout       = timeout_q;
    assign o_err_cnt       = err_cnt;
    assign o_first_err_idx = first_err;

endmodule

// File: tb/tb_operand_tester_chk.sv
// Bench for operand_tester_chk: an ideal latency-1 arithmetic DUT with optional
// faults, an operand monitor, and a reference sequence built from the
// operand-generation rules.
module tb_operand_tester_chk;

    localparam int          N    = 256;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [1:0]  i_mode = 2'b00;
    logic        i_op_sel = 1'b0;
    logic        i_stall = 1'b0;
    logic [7:0]  o_op_a, o_op_b;
    logic        o_op_valid;
    logic [15:0] i_result;
    logic        i_result_valid;
    logic        o_busy, o_done, o_pass, o_timeout;
    logic [15:0] o_err_cnt, o_first_err_idx;

    logic [15:0] mdl_res;
    logic        mdl_vld;
    int          mdl_idx;
    logic        inj_vld = 1'b0;
    logic        cur_sel = 1'b0;
    int          corrupt_idx = -1;
    int          drop_after = -1;

    int          cyc = 0;
    int          last_res_cyc = 0;
    logic [7:0]  cap_a [$];
    logic [7:0]  cap_b [$];
    logic [15:0] res_q [$];

    int          n_total = 0;
    int          n_pass = 0;
    int          done_cyc;
    logic        snap_busy, snap_v, snap_v2;
    logic [7:0]  snap_a, snap_b, snap_a2, snap_b2;

    always #5 clk = ~clk;

    operand_tester_chk #(
        .A(8), .B(8), .R_W(16), .N_VECTORS(N), .EXP_DEPTH(4), .SEED(SEED), .TIMEOUT(64)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_start(i_start), .i_mode(i_mode),
        .i_op_sel(i_op_sel), .i_stall(i_stall), .o_op_a(o_op_a), .o_op_b(o_op_b),
        .o_op_valid(o_op_valid), .i_result(i_result), .i_result_valid(i_result_valid),
        .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_timeout(o_timeout),
        .o_err_cnt(o_err_cnt), .o_first_err_idx(o_first_err_idx)
    );

    assign i_result       = mdl_res;
    assign i_result_valid = mdl_vld | inj_vld;

    // Ideal arithmetic DUT, latency 1, with optional corrupted or dropped results
    always @(posedge clk) begin
        if (rst || i_start) begin
            mdl_idx <= 0;
            mdl_vld <= 1'b0;
            mdl_res <= 16'd0;
        end else begin
            mdl_vld <= o_op_valid && (drop_after < 0 || mdl_idx <= drop_after);
            mdl_res <= (cur_sel ? {8'd0, o_op_a} * {8'd0, o_op_b} : {8'd0, o_op_a} + {8'd0, o_op_b})
                       ^ {15'd0, (o_op_valid && mdl_idx == corrupt_idx)};
            if (o_op_valid) mdl_idx <= mdl_idx + 1;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Record issued operands and returned results
    always @(negedge clk) begin
        if (i_start) begin
            cap_a.delete();
            cap_b.delete();
            res_q.delete();
        end else begin
            if (o_op_valid) begin
                cap_a.push_back(o_op_a);
                cap_b.push_back(o_op_b);
            end
            if (i_result_valid) begin
                res_q.push_back(i_result);
                last_res_cyc <= cyc;
            end
        end
    end

    // Index of the first captured pair differing from the reference; -2 on count error, -1 if clean
    function automatic int first_op_mismatch(input logic [1:0] mode);
        logic [15:0] s;
        logic [7:0]  ea, eb;
        s = SEED;
        if (cap_a.size() != N) return -2;
        for (int i = 0; i < N; i++) begin
            case (mode)
                2'b01: begin ea = s[7:0]; eb = s[15:8]; end
                2'b10: begin
                    case (i % 4)
                        0:       begin ea = 8'd0;   eb = 8'd0;   end
                        1:       begin ea = 8'd255; eb = 8'd255; end
                        2:       begin ea = 8'd255; eb = 8'd0;   end
                        default: begin ea = 8'd0;   eb = 8'd255; end
                    endcase
                end
                default: begin ea = 8'(i % 256); eb = 8'(255 - (i % 256)); end
            endcase
            if (cap_a[i] !== ea || cap_b[i] !== eb) return i;
            s = {s[14:0], ^(s & 16'hB400)};
        end
        return -1;
    endfunction

    task automatic run_vectors(input logic [1:0] mode, input logic sel, input int scen,
                               output int ncyc, output bit ok);
        cur_sel = sel;
        @(posedge clk); #1;
        i_mode = mode; i_op_sel = sel; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        ok = 1'b0;
        ncyc = 0;
        for (int k = 0; k < 4000; k++) begin
            case (scen)
                1:       i_stall = ($urandom_range(0, 3) == 0);
                2:       i_stall = (k >= 10 && k < 20);
                default: i_stall = 1'b0;
            endcase
            inj_vld = (scen == 3 && k == 0);
            @(negedge clk);
            if (k == 5) snap_busy = o_busy;
            if (k == 12) begin snap_a = o_op_a; snap_b = o_op_b; snap_v = o_op_valid; end
            if (k == 18) begin snap_a2 = o_op_a; snap_b2 = o_op_b; snap_v2 = o_op_valid; end
            if (o_done) begin
                ok = 1'b1;
                ncyc = k + 1;
                done_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        i_stall = 1'b0;
        inj_vld = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_total++; if (o_busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", o_busy); else n_pass++;
        n_total++; if (o_done !== 1'b0) $display("FAIL reset_done got %0b want 0", o_done); else n_pass++;
        n_total++; if (o_pass !== 1'b0) $display("FAIL reset_pass got %0b want 0", o_pass); else n_pass++;
        n_total++; if (o_timeout !== 1'b0) $display("FAIL reset_timeout got %0b want 0", o_timeout); else n_pass++;
        n_total++; if (o_op_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", o_op_valid); else n_pass++;
        n_total++; if ({o_op_a, o_op_b} !== 16'h0) $display("FAIL reset_ops got %h want 0000", {o_op_a, o_op_b}); else n_pass++;
        n_total++; if (o_err_cnt !== 16'd0) $display("FAIL reset_err got %0d want 0", o_err_cnt); else n_pass++;
        n_total++; if (o_first_err_idx !== 16'hFFFF) $display("FAIL reset_first got %h want ffff", o_first_err_idx); else n_pass++;
        // results arriving in IDLE are ignored
        @(posedge clk); #1 inj_vld = 1'b1;
        repeat (2) @(posedge clk);
        #1 inj_vld = 1'b0;
        @(negedge clk);
        n_total++; if (o_err_cnt !== 16'd0) $display("FAIL idle_result_err got %0d want 0", o_err_cnt); else n_pass++;
        n_total++; if (o_busy !== 1'b0) $display("FAIL idle_result_busy got %0b want 0", o_busy); else n_pass++;
    endtask

    task automatic test_sweep_add;
        int  nc, mm;
        bit  ok;
        run_vectors(2'b00, 1'b0, 0, nc, ok);
        mm = first_op_mismatch(2'b00);
        n_total++; if (!ok) $display("FAIL sweep_done no done within budget, got 0 want 1"); else n_pass++;
        n_total++; if (nc < 256 || nc > 270) $display("FAIL sweep_cycles got %0d want 256..270", nc); else n_pass++;
        n_total++; if (snap_busy !== 1'b1) $display("FAIL sweep_busy got %0b want 1", snap_busy); else n_pass++;
        n_total++; if (snap_v !== 1'b1) $display("FAIL sweep_streaming_valid got %0b want 1", snap_v); else n_pass++;
        n_total++; if (mm != -1) $display("FAIL sweep_operands first bad index %0d want -1", mm); else n_pass++;
        n_total++; if (o_pass !== 1'b1) $display("FAIL sweep_pass got %0b want 1", o_pass); else n_pass++;
        n_total++; if (o_err_cnt !== 16'd0) $display("FAIL sweep_err got %0d want 0", o_err_cnt); else n_pass++;
        n_total++; if (o_first_err_idx !== 16'hFFFF) $display("FAIL sweep_first got %h want ffff", o_first_err_idx); else n_pass++;
    endtask

    task automatic test_corner_mul;
        int  nc, mm;
        bit  ok;
        logic [15:0] r [4];
        run_vectors(2'b10, 1'b1, 0, nc, ok);
        mm = first_op_mismatch(2'b10);
        for (int i = 0; i < 4; i++) r[i] = (res_q.size() > i) ? res_q[i] : 16'hDEAD;
        n_total++; if (!ok) $display("FAIL corner_done no done within budget, got 0 want 1"); else n_pass++;
        n_total++; if (mm != -1) $display("FAIL corner_operands first bad index %0d want -1", mm); else n_pass++;
        n_total++; if ({r[0], r[1], r[2], r[3]} !== {16'd0, 16'd65025, 16'd0, 16'd0})
            $display("FAIL corner_results got %0d %0d %0d %0d want 0 65025 0 0", r[0], r[1], r[2], r[3]); else n_pass++;
        n_total++; if (o_pass !== 1'b1) $display("FAIL corner_pass got %0b want 1", o_pass); else n_pass++;
    endtask

    task automatic test_lfsr_random;
        int   nc, mm;
        bit   ok;
        logic sel;
        for (int rep = 0; rep < 2; rep++) begin
            sel = 1'($urandom_range(0, 1));
            run_vectors(2'b01, sel, 1, nc, ok);
            mm = first_op_mismatch(2'b01);
            n_total++; if (!ok) $display("FAIL lfsr_done rep %0d no done, got 0 want 1", rep); else n_pass++;
            n_total++; if (mm != -1) $display("FAIL lfsr_operands rep %0d first bad index %0d want -1", rep, mm); else n_pass++;
            n_total++; if (o_pass !== 1'b1 || o_err_cnt !== 16'd0)
                $display("FAIL lfsr_pass rep %0d sel %0b got pass %0b err %0d want 1 0", rep, sel, o_pass, o_err_cnt); else n_pass++;
        end
    endtask

    task automatic test_mismatch;
        int  nc;
        bit  ok;
        corrupt_idx = 5;
        run_vectors(2'b11, 1'b0, 0, nc, ok);
        corrupt_idx = -1;
        n_total++; if (!ok) $display("FAIL mismatch_done no done, got 0 want 1"); else n_pass++;
        n_total++; if (o_err_cnt !== 16'd1) $display("FAIL mismatch_err got %0d want 1", o_err_cnt); else n_pass++;
        n_total++; if (o_first_err_idx !== 16'd5) $display("FAIL mismatch_first got %0d want 5", o_first_err_idx); else n_pass++;
        n_total++; if (o_pass !== 1'b0) $display("FAIL mismatch_pass got %0b want 0", o_pass); else n_pass++;
    endtask

    task automatic test_stall;
        int  nc, mm;
        bit  ok;
        run_vectors(2'b00, 1'b0, 2, nc, ok);
        mm = first_op_mismatch(2'b00);
        n_total++; if (!ok) $display("FAIL stall_done no done, got 0 want 1"); else n_pass++;
        n_total++; if (snap_v !== 1'b0 || snap_v2 !== 1'b0) $display("FAIL stall_valid got %0b %0b want 0 0", snap_v, snap_v2); else n_pass++;
        n_total++; if ({snap_a, snap_b} !== {snap_a2, snap_b2})
            $display("FAIL stall_hold got %h want %h", {snap_a2, snap_b2}, {snap_a, snap_b}); else n_pass++;
        n_total++; if (mm != -1) $display("FAIL stall_operands first bad index %0d want -1", mm); else n_pass++;
        n_total++; if (o_pass !== 1'b1) $display("FAIL stall_pass got %0b want 1", o_pass); else n_pass++;
    endtask

    task automatic test_done_results;
        @(posedge clk); #1 inj_vld = 1'b1;
        repeat (3) @(posedge clk);
        #1 inj_vld = 1'b0;
        @(negedge clk);
        n_total++; if (o_err_cnt !== 16'd0) $display("FAIL done_result_err got %0d want 0", o_err_cnt); else n_pass++;
        n_total++; if (o_pass !== 1'b1 || o_done !== 1'b1)
            $display("FAIL done_result_status got pass %0b done %0b want 1 1", o_pass, o_done); else n_pass++;
    endtask

    task automatic test_spurious;
        int  nc;
        bit  ok;
        run_vectors(2'b00, 1'b0, 3, nc, ok);
        n_total++; if (!ok) $display("FAIL spurious_done no done, got 0 want 1"); else n_pass++;
        n_total++; if (o_err_cnt !== 16'd1) $display("FAIL spurious_err got %0d want 1", o_err_cnt); else n_pass++;
        n_total++; if (o_first_err_idx !== 16'hFFFF) $display("FAIL spurious_first got %h want ffff", o_first_err_idx); else n_pass++;
        n_total++; if (o_pass !== 1'b0) $display("FAIL spurious_pass got %0b want 0", o_pass); else n_pass++;
    endtask

    task automatic test_drop_timeout;
        int  nc, gap;
        bit  ok;
        drop_after = N - 4;
        run_vectors(2'b00, 1'b0, 0, nc, ok);
        drop_after = -1;
        gap = done_cyc - last_res_cyc;
        n_total++; if (!ok) $display("FAIL timeout_done no done, got 0 want 1"); else n_pass++;
        n_total++; if (o_timeout !== 1'b1) $display("FAIL timeout_flag got %0b want 1", o_timeout); else n_pass++;
        n_total++; if (gap < 64 || gap > 72) $display("FAIL timeout_gap got %0d want 64..72", gap); else n_pass++;
        n_total++; if (o_pass !== 1'b0) $display("FAIL timeout_pass got %0b want 0", o_pass); else n_pass++;
        n_total++; if (o_err_cnt !== 16'd0) $display("FAIL timeout_err got %0d want 0", o_err_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid_run;
        cur_sel = 1'b0;
        @(posedge clk); #1;
        i_mode = 2'b00; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (50) @(posedge clk);
        @(negedge clk);
        n_total++; if (o_busy !== 1'b1) $display("FAIL midrst_running got %0b want 1", o_busy); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++; if (o_busy !== 1'b0 || o_done !== 1'b0 || o_op_valid !== 1'b0)
            $display("FAIL midrst_status got busy %0b done %0b valid %0b want 0 0 0", o_busy, o_done, o_op_valid); else n_pass++;
        n_total++; if ({o_op_a, o_op_b} !== 16'h0) $display("FAIL midrst_ops got %h want 0000", {o_op_a, o_op_b}); else n_pass++;
        n_total++; if (o_err_cnt !== 16'd0 || o_first_err_idx !== 16'hFFFF || o_timeout !== 1'b0)
            $display("FAIL midrst_status2 got err %0d first %h to %0b want 0 ffff 0", o_err_cnt, o_first_err_idx, o_timeout); else n_pass++;
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        n_total++; if (o_busy !== 1'b0) $display("FAIL midrst_stays_idle got %0b want 0", o_busy); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_sweep_add();
        test_corner_mul();
        test_lfsr_random();
        test_mismatch();
        test_stall();
        test_done_results();
        test_spurious();
        test_drop_timeout();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
